button_events: RTL and testbench

Converts the debounced, active-high button level produced by the debouncer stage into discrete, buffered button events: PRESS, RELEASE, LONG (press held past a threshold) and REPEAT (periodic auto-repeat while held). Sits directly downstream of the debouncer and upstream of any consumer (MMIO status register, control FSM), which pulls events through a one-entry valid/ready buffer.

---
 rtl/button_events.sv | 137 +++++++++++++
 tb/tb_button_events.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Turns a debounced button level into PRESS / RELEASE / LONG / REPEAT events
// and presents them through a one-entry valid/ready buffer.
module button_events #(
    parameter int unsigned      CNT_W      = 25,
    parameter logic [CNT_W-1:0] CNT_LONG   = 25'd15_000_000,
    parameter logic [CNT_W-1:0] CNT_REPEAT = 25'd3_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn,
    input  logic       i_evt_ready,
    output logic       o_evt_valid,
    output logic [1:0] o_evt_code,
    output logic       o_held,
    output logic       o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam logic [1:0]       EVT_PRESS   = 2'd0;
    localparam logic [1:0]       EVT_RELEASE = 2'd1;
    localparam logic [1:0]       EVT_LONG    = 2'd2;
    localparam logic [1:0]       EVT_REPEAT  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_LONG - CNT_ONE;
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_REPEAT - CNT_ONE;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_q;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_gen;
    logic [1:0]       w_gen_code;
    logic             w_drain;
    logic             w_load;
    logic             w_drop;

    assign w_rise = i_btn & ~r_btn_q;
    assign w_fall = ~i_btn & r_btn_q;

    // Next-state / event decode; a fall always beats a threshold hit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gen       = 1'b0;
        w_gen_code  = EVT_PRESS;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_gen       = 1'b1;
                    w_gen_code  = EVT_PRESS;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_gen       = 1'b1;
                    w_gen_code  = EVT_RELEASE;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_gen       = 1'b1;
                    w_gen_code  = EVT_LONG;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_gen       = 1'b1;
                    w_gen_code  = EVT_RELEASE;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_gen       = 1'b1;
                    w_gen_code  = EVT_REPEAT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // A slot frees up in the same cycle the consumer drains it.
    assign w_drain = o_evt_valid & i_evt_ready;
    assign w_load  = w_gen & (~o_evt_valid | w_drain);
    assign w_drop  = w_gen & ~w_load;

    // State, counter and event buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_btn_q     <= 1'b0;
            o_held      <= 1'b0;
            o_evt_valid <= 1'b0;
            o_evt_code  <= EVT_PRESS;
            o_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_btn_q <= i_btn;
            o_held  <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                o_evt_valid <= 1'b1;
                o_evt_code  <= w_gen_code;
            end else if (w_drain) begin
                o_evt_valid <= 1'b0;
            end else begin
                o_evt_valid <= o_evt_valid;
            end
            if (w_drop) begin
                o_ovf <= 1'b1;
            end else begin
                o_ovf <= o_ovf;
            end
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: timing model from time-since-press arithmetic,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_button_events;

    localparam int unsigned      CNT_W = 25;
    localparam logic [CNT_W-1:0] P_LONG = 25'd8;
    localparam logic [CNT_W-1:0] P_REP  = 25'd4;
    localparam int               T_LONG = 8;
    localparam int               T_REP  = 4;

    logic       clk;
    logic       rst;
    logic       i_btn;
    logic       i_evt_ready;
    logic       o_evt_valid;
    logic [1:0] o_evt_code;
    logic       o_held;
    logic       o_ovf;

    int n_checks = 0;
    int n_errors = 0;

    button_events #(
        .CNT_W     (CNT_W),
        .CNT_LONG  (P_LONG),
        .CNT_REPEAT(P_REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn      (i_btn),
        .i_evt_ready(i_evt_ready),
        .o_evt_valid(o_evt_valid),
        .o_evt_code (o_evt_code),
        .o_held     (o_held),
        .o_ovf      (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int v, input int c, input int h, input int o);
        chk({tag, "_valid"}, int'(o_evt_valid), v);
        chk({tag, "_code"},  int'(o_evt_code),  c);
        chk({tag, "_held"},  int'(o_held),      h);
        chk({tag, "_ovf"},   int'(o_ovf),       o);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: events derive from cycles elapsed since PRESS, not from a counter
    logic       m_prev;
    logic       m_down;
    int         m_t;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_ovf;

    always @(posedge clk or posedge rst) begin : model
        logic       ev;
        logic [1:0] ec;
        int         t1;
        if (rst) begin
            m_prev  <= 1'b0;
            m_down  <= 1'b0;
            m_t     <= 0;
            m_valid <= 1'b0;
            m_code  <= 2'd0;
            m_ovf   <= 1'b0;
        end else begin
            ev = 1'b0;
            ec = 2'd0;
            t1 = m_t + 1;
            if (!m_down) begin
                if (i_btn && !m_prev) begin
                    ev = 1'b1; ec = 2'd0;
                    m_down <= 1'b1;
                    m_t    <= 0;
                end
            end else if (!i_btn) begin
                ev = 1'b1; ec = 2'd1;
                m_down <= 1'b0;
            end else begin
                m_t <= t1;
                if (t1 == T_LONG) begin
                    ev = 1'b1; ec = 2'd2;
                end else if (t1 > T_LONG && ((t1 - T_LONG) % T_REP) == 0) begin
                    ev = 1'b1; ec = 2'd3;
                end
            end
            m_prev <= i_btn;
            if (ev) begin
                if (!m_valid || i_evt_ready) begin
                    m_valid <= 1'b1;
                    m_code  <= ec;
                end else begin
                    m_ovf <= 1'b1;
                end
            end else if (m_valid && i_evt_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", int'(o_evt_valid), int'(m_valid));
        chk("cyc_code",  int'(o_evt_code),  int'(m_code));
        chk("cyc_held",  int'(o_held),      int'(m_down));
        chk("cyc_ovf",   int'(o_ovf),       int'(m_ovf));
    end

    initial begin
        rst = 1'b1;
        i_btn = 1'b0;
        i_evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        idle(1);

        // Short press: PRESS then RELEASE, nothing in between
        i_btn = 1'b1;
        @(negedge clk); expect_out("t1_press", 1, 0, 1, 0);
        idle(4);
        i_btn = 1'b0;
        @(negedge clk); expect_out("t1_release", 1, 1, 0, 0);
        idle(3);

        // Long hold: LONG@9, REPEAT@13,@17, RELEASE@21
        i_btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 9)                expect_out("t2_long", 1, 2, 1, 0);
            else if (c == 10)          expect_out("t2_drained", 0, 2, 1, 0);
            else if (c == 13 || c == 17) expect_out("t2_repeat", 1, 3, 1, 0);
        end
        i_btn = 1'b0;
        @(negedge clk); expect_out("t2_release", 1, 1, 0, 0);
        idle(3);

        // Fall on the LONG threshold cycle: RELEASE only
        i_btn = 1'b1;
        idle(8);
        expect_out("t3_pre", 0, 0, 1, 0);
        i_btn = 1'b0;
        @(negedge clk); expect_out("t3_release", 1, 1, 0, 0);
        @(negedge clk); expect_out("t3_nolong", 0, 1, 0, 0);
        idle(2);

        // LONG stalled, then drained on the edge REPEAT loads
        i_btn = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 8) i_evt_ready = 1'b0;
            if (c >= 9 && c <= 12) expect_out("b2b_long", 1, 2, 1, 0);
            if (c == 12) i_evt_ready = 1'b1;
            if (c == 13) expect_out("b2b_repeat", 1, 3, 1, 0);
        end
        i_btn = 1'b0;
        @(negedge clk); expect_out("b2b_release", 1, 1, 0, 0);
        idle(3);

        // Full buffer drops RELEASE and sets sticky overflow
        i_evt_ready = 1'b0;
        i_btn = 1'b1;
        @(negedge clk); expect_out("t4_press", 1, 0, 1, 0);
        idle(2);
        i_btn = 1'b0;
        @(negedge clk); expect_out("t4_drop", 1, 0, 0, 1);
        i_evt_ready = 1'b1;
        @(negedge clk); expect_out("t4_drain", 0, 0, 0, 1);
        idle(2);

        // Asynchronous reset while held with an event pending
        i_evt_ready = 1'b0;
        i_btn = 1'b1;
        idle(10);
        expect_out("t5_held", 1, 0, 1, 1);
        #2 rst = 1'b1;
        #1 expect_out("t5_async_rst", 0, 0, 0, 0);
        i_evt_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); expect_out("t5_fresh_press", 1, 0, 1, 0);
        i_btn = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
